reg_dump_uart_tx: RTL and testbench
===================================

// Module: reg_dump_uart_tx
// PURPOSE
//  Read-side companion of the 8x16 register file: consumes its debug taps S0..S7
//  and streams a snapshot of all eight registers out a UART TX pin as ASCII hex.
//  Sits between the register file debug outputs and the board serial port.
//  Each dump is 8 lines of the form "Rn=XXXX\r\n", giving 72 characters in 8N1 framing.
// PARAMETERS
//  CLKS_PER_BIT  434  clk cycles per UART bit (50 MHz / 115200); legal range >= 2
//  DW            16   register width; fixed to 4 hex digits per line
// PORTS
//  clk      in   1   system clock, rising edge
//  rst_n    in   1   asynchronous reset, active low
//  start    in   1   dump request, level-sampled only in IDLE
//  S0..S7   in   16  register file debug taps (S0 = r0 ... S7 = r7)
//  tx       out  1   UART serial out; idles high
//  busy     out  1   high from the capture edge until the end of the last stop bit
//  done     out  1   one-cycle pulse when the dump completes
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - tx=1, busy=0, done=0; FSM -> IDLE; counters and snapshot cleared.
//  - A dump in progress is abandoned with no partial completion, and done is not pulsed.
//  FSM states: IDLE -> START -> DATA -> STOP -> (START of next char | IDLE).
//  IDLE:
//  - On a clk edge with start=1, all 8 S inputs are latched into the shadow regs.
//  - char index <= 0; tx <= 0; busy <= 1; state <= START.
//  - Capture to tx-low latency: 1 edge.
//  START:
//  - tx=0 for CLKS_PER_BIT cycles, then DATA.
//  DATA:
//  - 8 bits, LSB first, each held CLKS_PER_BIT cycles, then STOP.
//  STOP:
//  - tx=1 for CLKS_PER_BIT cycles.
//  - If chars remain: next char, START (no idle gap).
//  - After char 71: state <= IDLE, busy <= 0, done <= 1 for exactly 1 cycle (same edge).
//  Character sequence, for line i = 0..7 (char index = 9*i + k):
//  - k=0 'R' 0x52; k=1 '0'+i; k=2 '=' 0x3D; k=3..6 hex nibbles of shadow[i], bits [15:12] first.
//  - k=7 CR 0x0D; k=8 LF 0x0A.
//  Hex digit encoding:
//  - n<10 -> 0x30+n; n>=10 -> 0x41+(n-10), uppercase.
//  - Digits come from the shadow copy only; S changes after capture have no effect.
//  Timing:
//  - Dump length is 72*10*CLKS_PER_BIT cycles from tx falling to the done edge.
//  - tx, busy and done are registered outputs, with no combinational path from inputs.
//  Start handling:
//  - start while busy is ignored and not queued.
//  - start held high at the done edge: the FSM sees IDLE on the next edge and begins a new
//    dump, so back-to-back dumps are separated by 1 idle cycle with tx=1.
//  Counters:
//  - Bit timer counts 0..CLKS_PER_BIT-1 and wraps.
//  - Bit counter counts 0..7; char counter counts 0..71.
//  - No counter exceeds its range; out-of-range states return to IDLE.
// TESTING
//  Bench uses CLKS_PER_BIT=4 and a UART monitor sampling mid-bit.
//  T1 reset: rst_n=0 at any time -> tx=1, busy=0, done=0 asynchronously, with no clk edge needed.
//  T2 basic dump: S0=0000, S1=BEEF, S2=0001, S3=00A0, S4=FFFF, S5=1234, S6=C0DE, S7=8000; 1-cycle start
//     -> decoded "R0=0000\r\nR1=BEEF\r\nR2=0001\r\nR3=00A0\r\nR4=FFFF\r\nR5=1234\r\nR6=C0DE\r\nR7=8000\r\n".
//  T3 snapshot: start with S3=00A0, then set S3=5555 during line 0 -> line 3 reads "R3=00A0".
//  T4 timing/busy: tx falls 1 edge after start; done pulses after exactly 2880 cycles;
//     busy is high for the same span; done is high for 1 cycle.
//  T5 start while busy: pulse start at chars 10 and 71 -> exactly 72 chars, 1 done pulse.
//     Then hold start high -> second dump begins after 1 idle cycle.
//  T6 reset mid-op: rst_n low for 2 cycles mid-bit of char 30 -> tx=1, no done pulse.
//     A new start then gives a full dump beginning at "R0=".

Source files
------------

// File: rtl/reg_dump_uart_tx.sv
// reg_dump_uart_tx: snapshots eight register-file debug taps and streams them out an
// 8N1 UART as eight "Rn=XXXX\r\n" lines of uppercase ASCII hex (72 characters per dump).
module reg_dump_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DW           = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] S0,
  input  logic [DW-1:0] S1,
  input  logic [DW-1:0] S2,
  input  logic [DW-1:0] S3,
  input  logic [DW-1:0] S4,
  input  logic [DW-1:0] S5,
  input  logic [DW-1:0] S6,
  input  logic [DW-1:0] S7,
  output logic          tx,
  output logic          busy,
  output logic          done
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_LINE  = 3'd7;
  localparam logic [3:0]    LAST_K     = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t         r_state;
  logic [TW-1:0]  r_timer;
  logic [2:0]     r_bit;
  logic [2:0]     r_line;
  logic [3:0]     r_k;
  logic           r_tx;
  logic           r_busy;
  logic           r_done;
  logic [DW-1:0]  r_shadow [0:7];

  state_t         w_state_nxt;
  logic [TW-1:0]  w_timer_nxt;
  logic [2:0]     w_bit_nxt;
  logic [2:0]     w_line_nxt;
  logic [3:0]     w_k_nxt;
  logic           w_tx_nxt;
  logic           w_busy_nxt;
  logic           w_done_nxt;
  logic           w_capture;
  logic           w_bit_end;
  logic           w_k_bad;
  logic [2:0]     w_bit_inc;
  logic [DW-1:0]  w_cur_reg;
  logic [7:0]     w_char;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    logic [7:0] a;
    if (n < 4'd10) begin
      a = 8'h30 + {4'h0, n};
    end else begin
      a = 8'h37 + {4'h0, n};
    end
    return a;
  endfunction

  // >= rather than == so a corrupted timer still wraps back into range
  assign w_bit_end = (r_timer >= TIMER_LAST);
  assign w_k_bad   = (r_k > LAST_K);
  assign w_bit_inc = r_bit + 3'd1;
  assign w_cur_reg = r_shadow[r_line];

  // Character generator: line index r_line, position k within "Rn=XXXX\r\n"
  always_comb begin
    w_char = 8'h00;
    case (r_k)
      4'd0:    w_char = 8'h52;
      4'd1:    w_char = 8'h30 + {5'd0, r_line};
      4'd2:    w_char = 8'h3D;
      4'd3:    w_char = hex_ascii(w_cur_reg[15:12]);
      4'd4:    w_char = hex_ascii(w_cur_reg[11:8]);
      4'd5:    w_char = hex_ascii(w_cur_reg[7:4]);
      4'd6:    w_char = hex_ascii(w_cur_reg[3:0]);
      4'd7:    w_char = 8'h0D;
      4'd8:    w_char = 8'h0A;
      default: w_char = 8'h00;
    endcase
  end

  // Next-state and registered-output logic for the UART framing FSM
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_bit_nxt   = r_bit;
    w_line_nxt  = r_line;
    w_k_nxt     = r_k;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_capture   = 1'b0;

    if ((r_state != ST_IDLE) && w_k_bad) begin
      w_state_nxt = ST_IDLE;
      w_timer_nxt = {TW{1'b0}};
      w_tx_nxt    = 1'b1;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_tx_nxt    = 1'b1;
          w_busy_nxt  = 1'b0;
          w_timer_nxt = {TW{1'b0}};
          if (start) begin
            w_capture   = 1'b1;
            w_line_nxt  = 3'd0;
            w_k_nxt     = 4'd0;
            w_bit_nxt   = 3'd0;
            w_tx_nxt    = 1'b0;
            w_busy_nxt  = 1'b1;
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            w_timer_nxt = {TW{1'b0}};
            w_bit_nxt   = 3'd0;
            w_tx_nxt    = w_char[0];
            w_state_nxt = ST_DATA;
          end else begin
            w_timer_nxt = r_timer + TW'(1'b1);
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            w_timer_nxt = {TW{1'b0}};
            if (r_bit == 3'd7) begin
              w_tx_nxt    = 1'b1;
              w_state_nxt = ST_STOP;
            end else begin
              w_bit_nxt = w_bit_inc;
              w_tx_nxt  = w_char[w_bit_inc];
            end
          end else begin
            w_timer_nxt = r_timer + TW'(1'b1);
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            w_timer_nxt = {TW{1'b0}};
            if ((r_line == LAST_LINE) && (r_k == LAST_K)) begin
              w_state_nxt = ST_IDLE;
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
              w_tx_nxt    = 1'b1;
            end else begin
              // Next character follows the stop bit immediately, no idle gap
              if (r_k == LAST_K) begin
                w_k_nxt    = 4'd0;
                w_line_nxt = r_line + 3'd1;
              end else begin
                w_k_nxt = r_k + 4'd1;
              end
              w_tx_nxt    = 1'b0;
              w_state_nxt = ST_START;
            end
          end else begin
            w_timer_nxt = r_timer + TW'(1'b1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = {TW{1'b0}};
          w_tx_nxt    = 1'b1;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  // FSM state, counters and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_timer <= {TW{1'b0}};
      r_bit   <= 3'd0;
      r_line  <= 3'd0;
      r_k     <= 4'd0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_bit   <= w_bit_nxt;
      r_line  <= w_line_nxt;
      r_k     <= w_k_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Shadow snapshot of the register taps, taken only on the capture edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_shadow[i] <= {DW{1'b0}};
      end
    end else if (w_capture) begin
      r_shadow[0] <= S0;
      r_shadow[1] <= S1;
      r_shadow[2] <= S2;
      r_shadow[3] <= S3;
      r_shadow[4] <= S4;
      r_shadow[5] <= S5;
      r_shadow[6] <= S6;
      r_shadow[7] <= S7;
    end else begin
      for (int i = 0; i < 8; i++) begin
        r_shadow[i] <= r_shadow[i];
      end
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_reg_dump_uart_tx.sv
// tb_reg_dump_uart_tx: drives random register snapshots, decodes the UART line mid-bit
// and compares against a text-level model of the expected dump.
module tb_reg_dump_uart_tx;

  localparam int CPB = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] sv [8];
  logic        tx;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int frame_err = 0;

  logic [7:0]  rx_q  [$];
  logic [7:0]  exp_q [$];
  logic [15:0] cap [8];

  reg_dump_uart_tx #(.CLKS_PER_BIT(CPB), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .S0(sv[0]), .S1(sv[1]), .S2(sv[2]), .S3(sv[3]),
    .S4(sv[4]), .S5(sv[5]), .S6(sv[6]), .S7(sv[7]),
    .tx(tx), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse and busy-span bookkeeping, sampled on the falling edge
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt = done_cnt + 1;
    if (busy === 1'b1) busy_cnt = busy_cnt + 1;
  end

  // UART receiver: start detected on a low falling-edge sample, bits sampled mid-bit
  initial begin : uart_mon
    logic [7:0] b;
    bit ok;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        b = 8'h00;
        ok = 1'b1;
        for (int w = 1; w <= 38; w++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) ok = 1'b0;
          if (w == 2 && tx !== 1'b0) ok = 1'b0;
          if (w >= 6 && w <= 34 && ((w - 6) % 4) == 0) b[(w - 6) / 4] = tx;
        end
        if (ok && tx === 1'b1) begin
          rx_q.push_back(b);
        end else if (ok) begin
          frame_err = frame_err + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic build_exp();
    int n;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h52);
      exp_q.push_back(8'(48 + i));
      exp_q.push_back(8'h3D);
      for (int d = 3; d >= 0; d--) begin
        n = (int'(cap[i]) >> (4 * d)) & 15;
        exp_q.push_back((n < 10) ? 8'(48 + n) : 8'(65 + n - 10));
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic compare_dump(input string tag);
    int lim;
    chk({tag, "_len"}, rx_q.size(), 72);
    chk({tag, "_frame"}, frame_err, 0);
    lim = (rx_q.size() < 72) ? rx_q.size() : 72;
    for (int k = 0; k < lim; k++) begin
      chk($sformatf("%s_char%0d", tag, k), rx_q[k], exp_q[k]);
    end
  endtask

  task automatic randomize_s();
    for (int i = 0; i < 8; i++) sv[i] = 16'($urandom);
  endtask

  task automatic start_dump(output int c0);
    @(negedge clk); #1;
    for (int i = 0; i < 8; i++) cap[i] = sv[i];
    build_exp();
    rx_q.delete();
    done_cnt = 0;
    busy_cnt = 0;
    frame_err = 0;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    chk("tx_fall_1edge", tx, 1'b0);
    chk("busy_rise", busy, 1'b1);
    c0 = cyc;
  endtask

  task automatic wait_done(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_rx(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      if (rx_q.size() >= n) ok = 1'b1;
    end
    #1;
  endtask

  task automatic finish_dump(input string tag, input int c0);
    bit seen;
    int c1;
    wait_done(3000, seen);
    chk({tag, "_done_seen"}, seen, 1'b1);
    c1 = cyc;
    repeat (4) @(negedge clk);
    #1;
    chk({tag, "_dump_cycles"}, c1 - c0, 720 * CPB);
    chk({tag, "_busy_span"}, busy_cnt, 720 * CPB);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_idle_tx"}, tx, 1'b1);
    compare_dump(tag);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  c0;
    int  dc;
    bit  ok;
    bit  seen;

    rst_n = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) sv[i] = 16'h0000;

    // Asynchronous reset, observed before any clock edge
    #3 rst_n = 1'b0;
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("idle_tx", tx, 1'b1);
    chk("idle_busy", busy, 1'b0);

    // Fixed-pattern dump with timing checks
    sv[0] = 16'h0000; sv[1] = 16'hBEEF; sv[2] = 16'h0001; sv[3] = 16'h00A0;
    sv[4] = 16'hFFFF; sv[5] = 16'h1234; sv[6] = 16'hC0DE; sv[7] = 16'h8000;
    start_dump(c0);
    finish_dump("basic", c0);
    chk("basic_have_line1", rx_q.size() >= 16, 1'b1);
    if (rx_q.size() >= 16) begin
      chk("basic_beef", {rx_q[12], rx_q[13], rx_q[14], rx_q[15]}, 32'h42454546);
      chk("basic_line1_hdr", {8'h00, rx_q[9], rx_q[10], rx_q[11]}, 32'h0052313D);
    end

    // Snapshot isolation: taps change after capture
    randomize_s();
    sv[3] = 16'h00A0;
    start_dump(c0);
    repeat (15) @(negedge clk);
    #1;
    randomize_s();
    sv[3] = 16'h5555;
    finish_dump("snap", c0);
    chk("snap_have_line3", rx_q.size() >= 34, 1'b1);
    if (rx_q.size() >= 34) begin
      chk("snap_r3", {rx_q[30], rx_q[31], rx_q[32], rx_q[33]}, 32'h30304130);
    end

    // start pulses while busy are ignored
    randomize_s();
    start_dump(c0);
    wait_rx(10, ok);
    chk("busy_reach_c10", ok, 1'b1);
    start = 1'b1; @(negedge clk); #1; start = 1'b0;
    wait_rx(71, ok);
    chk("busy_reach_c71", ok, 1'b1);
    repeat (10) @(negedge clk);
    #1 start = 1'b1; @(negedge clk); #1; start = 1'b0;
    finish_dump("ignore", c0);

    // start held high: back-to-back dumps with one idle cycle
    @(negedge clk); #1;
    randomize_s();
    for (int i = 0; i < 8; i++) cap[i] = sv[i];
    build_exp();
    rx_q.delete();
    done_cnt = 0;
    frame_err = 0;
    start = 1'b1;
    wait_done(3000, seen);
    chk("b2b_done1_seen", seen, 1'b1);
    chk("b2b_gap_tx", tx, 1'b1);
    chk("b2b_gap_busy", busy, 1'b0);
    @(negedge clk);
    chk("b2b_restart_tx", tx, 1'b0);
    chk("b2b_restart_busy", busy, 1'b1);
    #1 start = 1'b0;
    compare_dump("b2b_first");
    rx_q.delete();
    wait_done(3000, seen);
    chk("b2b_done2_seen", seen, 1'b1);
    repeat (4) @(negedge clk);
    #1;
    chk("b2b_done_pulses", done_cnt, 2);
    compare_dump("b2b_second");

    // Reset mid-character abandons the dump without a done pulse
    randomize_s();
    start_dump(c0);
    wait_rx(30, ok);
    chk("rst_reach_c30", ok, 1'b1);
    repeat (8) @(negedge clk);
    #2;
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (60) @(negedge clk);
    #1;
    chk("midrst_no_done", done_cnt, dc);
    chk("midrst_partial", rx_q.size(), 30);
    chk("midrst_idle_tx", tx, 1'b1);
    chk("midrst_idle_busy", busy, 1'b0);
    randomize_s();
    start_dump(c0);
    finish_dump("after_rst", c0);

    // Further random snapshots
    for (int r = 0; r < 2; r++) begin
      randomize_s();
      start_dump(c0);
      finish_dump($sformatf("rand%0d", r), c0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
